accum_arbiter: RTL and testbench
================================

ACCUM_ARBITER -- requirements
Module: accum_arbiter

Interface
REQ-001 Parameter: ACC_W, 32, accumulator width in bits; legal range 9..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  2  per-requester beat valid; bit i = requester i.
REQ-005 req_ready  output  2  per-requester beat accept.
REQ-006 req_data  input  16  beat data; requester i in bits [8i+7:8i].
REQ-007 req_signed  input  2  beat data signed (1) or unsigned (0), sampled per beat.
REQ-008 req_last  input  2  final beat of burst.
REQ-009 acc_out  output  ACC_W  signed accumulated result.
REQ-010 acc_valid  output  1  one-cycle result strobe.
REQ-011 acc_owner  output  1  requester index owning current/last burst.
REQ-012 acc_ovf  output  1  overflow flag for last result.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states IDLE, ACCUM, RESULT; all outputs registered or decoded from state only.
REQ-015 IDLE: req_ready=0; if any req_valid, grant per round-robin, register acc_owner, next state ACCUM.
REQ-016 Round-robin: pointer selects preferred requester; both valid -> preferred wins; one valid -> it wins.
REQ-017 ACCUM: req_ready[acc_owner]=1, other bit 0; beat accepted when valid&ready.
REQ-018 Accepted beat data extended to ACC_W: sign-extend if req_signed, else zero-extend.
REQ-019 First accepted beat of burst loads acc with extended data; later beats add to acc.
REQ-020 Accepted beat with req_last -> RESULT; owner keeps grant until then; valid low stalls without penalty.
REQ-021 RESULT: acc_valid=1 exactly one cycle, pointer <= ~acc_owner, next state IDLE.
REQ-022 Latency: acc_valid asserted the cycle after the last beat's accept edge; acc_out, acc_owner, acc_ovf hold until next RESULT.
REQ-023 Min gap between bursts: IDLE one cycle; non-owner request pending during burst is served next.
REQ-024 Single-beat burst (first beat has req_last) legal; result = that beat.

Reset
REQ-025 rstn low at clock edge: state IDLE, acc_out 0, acc_valid 0, acc_owner 0, acc_ovf 0, pointer 0, busy 0, req_ready 0.
REQ-026 Reset mid-burst abandons burst; no acc_valid generated; next burst starts from fresh load.

Configuration
REQ-027 Macro ACCUM_ARBITER_SAT_EN selects overflow behaviour.
REQ-028 Without macro: arithmetic wraps modulo 2^ACC_W; acc_ovf constant 0.
REQ-029 With macro: signed saturation to 2^(ACC_W-1)-1 / -2^(ACC_W-1); acc_ovf set if any beat of the burst saturated, cleared on burst first beat.

Structure
REQ-030 Package accum_arbiter_pkg holds state_t enum, NREQ=2, DATA_W=8.
REQ-031 Sub-module rr_arb2 implements two-requester round-robin grant and pointer.

Verification
REQ-032 Req0 unsigned beats 0xFF,0x01,0x10(last) -> acc_out=0x00000110, acc_owner=0, acc_valid one cycle after last accept.
REQ-033 Req1 signed beats 0x80,0xFF(last) -> acc_out=0xFFFFFF7F (-129), acc_owner=1.
REQ-034 Both valid right after reset, single beats 0x05/0x07 -> req0 result 5 first, then req1 result 7; no beat of req1 accepted during req0 burst.
REQ-035 ACC_W=10, req0 signed 0x7F x5 -> no macro: acc_out=0x27B (-389), acc_ovf=0; with macro: 0x1FF, acc_ovf=1.
REQ-036 rstn low after 2 accepted beats -> all outputs at reset values, no acc_valid; new burst 0x03(last) -> acc_out=3.

Source files
------------

// File: rtl/accum_arbiter_pkg.sv
// Shared types and constants for the two-requester accumulating arbiter.
package accum_arbiter_pkg;

    localparam int NREQ   = 2;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant; the pointer names the preferred requester.
module rr_arb2
    import accum_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic [NREQ-1:0] req,
    input  logic            ptr_upd,
    input  logic            ptr_next,
    output logic            gnt_idx,
    output logic            gnt_any
);

    logic ptr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr <= 1'b0;
        end else if (ptr_upd) begin
            ptr <= ptr_next;
        end
    end

    assign gnt_any = |req;
    assign gnt_idx = req[ptr] ? ptr : ~ptr;

endmodule

// File: rtl/accum_arbiter.sv
// Arbitrates two burst requesters and accumulates the granted burst into one result.
// Define ACCUM_ARBITER_SAT_EN for signed saturation with overflow flag; default wraps.
module accum_arbiter
    import accum_arbiter_pkg::*;
#(
    parameter int ACC_W = 32
)
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic [NREQ-1:0]        req_signed,
    input  logic [NREQ-1:0]        req_last,
    output logic signed [ACC_W-1:0] acc_out,
    output logic                   acc_valid,
    output logic                   acc_owner,
    output logic                   acc_ovf,
    output logic                   busy
);

    state_t              state, state_nxt;
    logic [ACC_W-1:0]    acc, acc_nxt, beat_ext;
    logic [DATA_W-1:0]   beat_data;
    logic                first_beat;
    logic                beat_fire, beat_last;
    logic                gnt_idx, gnt_any, ptr_upd;

    rr_arb2 u_arb (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req_valid),
        .ptr_upd  (ptr_upd),
        .ptr_next (~acc_owner),
        .gnt_idx  (gnt_idx),
        .gnt_any  (gnt_any)
    );

    assign beat_data = acc_owner ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
    assign beat_fire = (state == ACCUM) && req_valid[acc_owner];
    assign beat_last = req_last[acc_owner];
    assign beat_ext  = req_signed[acc_owner]
                     ? {{(ACC_W-DATA_W){beat_data[DATA_W-1]}}, beat_data}
                     : {{(ACC_W-DATA_W){1'b0}}, beat_data};

`ifdef ACCUM_ARBITER_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] sum_wide;
    logic           sat_hit, ovf_run, ovf_nxt;

    // Overflow shows as disagreement between the two top bits of the sign-extended sum.
    always_comb begin
        sum_wide = {acc[ACC_W-1], acc} + {beat_ext[ACC_W-1], beat_ext};
        sat_hit  = !first_beat && (sum_wide[ACC_W] != sum_wide[ACC_W-1]);
        if (first_beat) begin
            acc_nxt = beat_ext;
        end else if (sat_hit) begin
            acc_nxt = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_nxt = sum_wide[ACC_W-1:0];
        end
        ovf_nxt = !first_beat && (ovf_run || sat_hit);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf_run <= 1'b0;
            acc_ovf <= 1'b0;
        end else if (beat_fire) begin
            ovf_run <= ovf_nxt;
            if (beat_last) acc_ovf <= ovf_nxt;
        end
    end
`else
    assign acc_nxt = first_beat ? beat_ext : acc + beat_ext;
    assign acc_ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            acc        <= '0;
            acc_out    <= '0;
            acc_owner  <= 1'b0;
            first_beat <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == IDLE && gnt_any) begin
                acc_owner  <= gnt_idx;
                first_beat <= 1'b1;
            end
            if (beat_fire) begin
                acc        <= acc_nxt;
                first_beat <= 1'b0;
                if (beat_last) acc_out <= acc_nxt;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        ptr_upd   = 1'b0;
        unique case (state)
            IDLE:    if (gnt_any) state_nxt = ACCUM;
            ACCUM:   if (beat_fire && beat_last) state_nxt = RESULT;
            RESULT: begin
                state_nxt = IDLE;
                ptr_upd   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign acc_valid = (state == RESULT);
    assign busy      = (state != IDLE);
    assign req_ready = (state == ACCUM) ? (acc_owner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_accum_arbiter.sv
// Scoreboard bench: per-requester drivers, a result monitor, and an arithmetic reference model.
module tb_accum_arbiter;

    typedef struct {
        logic [7:0] data;
        bit         sgn;
        bit         last;
    } beat_t;

    typedef struct {
        logic [63:0] r32;
        bit          o32;
        logic [63:0] r10;
        bit          o10;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        v0, v1, s0, s1, l0, l1;
    logic [7:0]  d0, d1;
    logic [1:0]  req_valid, req_signed, req_last;
    logic [15:0] req_data;

    logic [1:0]  req_ready, req_ready10;
    logic [31:0] acc_out32;
    logic [9:0]  acc_out10;
    logic        acc_valid, acc_owner, acc_ovf, busy;
    logic        acc_valid10, acc_owner10, acc_ovf10, busy10;

    assign req_valid  = {v1, v0};
    assign req_signed = {s1, s0};
    assign req_last   = {l1, l0};
    assign req_data   = {d1, d0};

    always #5 clk = ~clk;

    accum_arbiter #(.ACC_W(32)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_signed(req_signed), .req_last(req_last),
        .acc_out(acc_out32), .acc_valid(acc_valid), .acc_owner(acc_owner),
        .acc_ovf(acc_ovf), .busy(busy)
    );

    accum_arbiter #(.ACC_W(10)) dut10 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready10),
        .req_data(req_data), .req_signed(req_signed), .req_last(req_last),
        .acc_out(acc_out10), .acc_valid(acc_valid10), .acc_owner(acc_owner10),
        .acc_ovf(acc_ovf10), .busy(busy10)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    cnt0 = 0, cnt1 = 0;
    int    lacc0 = 0, lacc1 = 0;
    bit    stall_en = 1'b0;
    bit    rr_pend = 1'b0, rr_next = 1'b0;
    bit    prev_valid = 1'b0;
    beat_t bq0[$], bq1[$], bb[$];
    exp_t  eq0[$], eq1[$];
    bit    owner_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference: extend each beat, load on first, then add with wrap or clamp at width w.
    function automatic void model(input beat_t b[$], input int w, output logic [63:0] r, output bit o);
        longint acc, e, span, hi, lo;
        span = longint'(1) << w;
        hi   = (span >> 1) - 1;
        lo   = -(span >> 1);
        acc  = 0;
        o    = 1'b0;
        foreach (b[i]) begin
            e = b[i].sgn ? longint'($signed(b[i].data)) : longint'(b[i].data);
            if (i == 0) begin
                acc = e;
                o   = 1'b0;
            end else begin
                acc = acc + e;
`ifdef ACCUM_ARBITER_SAT_EN
                if (acc > hi) begin acc = hi; o = 1'b1; end
                else if (acc < lo) begin acc = lo; o = 1'b1; end
`else
                acc = acc & (span - 1);
                if (acc > hi) acc = acc - span;
`endif
            end
        end
        r = 64'(acc) & 64'(span - 1);
    endfunction

    task automatic add_beat(input logic [7:0] d, input bit s, input bit l);
        beat_t b;
        b.data = d; b.sgn = s; b.last = l;
        bb.push_back(b);
    endtask

    task automatic push_exp(input int id, input beat_t b[$]);
        exp_t e;
        model(b, 32, e.r32, e.o32);
        model(b, 10, e.r10, e.o10);
        if (id == 0) eq0.push_back(e); else eq1.push_back(e);
    endtask

    task automatic push_beats(input int id, input beat_t b[$]);
        foreach (b[i]) begin
            if (id == 0) bq0.push_back(b[i]); else bq1.push_back(b[i]);
        end
    endtask

    task automatic push_burst(input int id);
        push_exp(id, bb);
        push_beats(id, bb);
        bb.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rr_pend = 1'b0;
        check("rst_acc_out",   64'(acc_out32), 64'd0);
        check("rst_acc_out10", 64'(acc_out10), 64'd0);
        check("rst_acc_valid", 64'({acc_valid10, acc_valid}), 64'd0);
        check("rst_acc_owner", 64'({acc_owner10, acc_owner}), 64'd0);
        check("rst_acc_ovf",   64'({acc_ovf10, acc_ovf}), 64'd0);
        check("rst_busy",      64'({busy10, busy}), 64'd0);
        check("rst_req_ready", 64'({req_ready10, req_ready}), 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((bq0.size() != 0 || bq1.size() != 0 || eq0.size() != 0 || eq1.size() != 0 || busy)
               && t < 6000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 6000) begin
            bound_fail(name);
            bq0.delete(); bq1.delete(); eq0.delete(); eq1.delete();
        end
    endtask

    // Requester 0 driver: holds each beat until a ready edge outside reset takes it.
    initial begin
        beat_t b;
        int    t;
        bit    done;
        v0 = 1'b0; d0 = '0; s0 = 1'b0; l0 = 1'b0;
        forever begin
            if (bq0.size() == 0) begin
                v0 = 1'b0;
                @(posedge clk);
                #1;
            end else begin
                b = bq0.pop_front();
                if (stall_en && $urandom_range(0, 2) == 0) begin
                    v0 = 1'b0;
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                v0 = 1'b1; d0 = b.data; s0 = b.sgn; l0 = b.last;
                t = 0; done = 1'b0;
                while (!done) begin
                    @(negedge clk);
                    if (req_ready[0]) begin
                        @(posedge clk);
                        if (rstn) done = 1'b1;
                        #1;
                    end
                    t++;
                    if (!done && t > 3000) begin
                        bound_fail("req0_accept");
                        done = 1'b1;
                    end
                end
                cnt0++;
                lacc0 = cyc;
            end
        end
    end

    initial begin
        beat_t b;
        int    t;
        bit    done;
        v1 = 1'b0; d1 = '0; s1 = 1'b0; l1 = 1'b0;
        forever begin
            if (bq1.size() == 0) begin
                v1 = 1'b0;
                @(posedge clk);
                #1;
            end else begin
                b = bq1.pop_front();
                if (stall_en && $urandom_range(0, 2) == 0) begin
                    v1 = 1'b0;
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                v1 = 1'b1; d1 = b.data; s1 = b.sgn; l1 = b.last;
                t = 0; done = 1'b0;
                while (!done) begin
                    @(negedge clk);
                    if (req_ready[1]) begin
                        @(posedge clk);
                        if (rstn) done = 1'b1;
                        #1;
                    end
                    t++;
                    if (!done && t > 3000) begin
                        bound_fail("req1_accept");
                        done = 1'b1;
                    end
                end
                cnt1++;
                lacc1 = cyc;
            end
        end
    end

    // Monitor: pops the owner's expected result on every strobe and checks arbitration order.
    always @(negedge clk) begin
        exp_t e;
        if (rstn === 1'b1) begin
            if (req_ready != 2'b00) check("ready_onehot", 64'($countones(req_ready)), 64'd1);
            if (acc_valid) begin
                check("valid_pulse", 64'(prev_valid), 64'd0);
                check("valid10_align", 64'({acc_valid10, acc_owner10}), 64'({1'b1, acc_owner}));
                check("latency", 64'(cyc), 64'(acc_owner ? lacc1 : lacc0));
                if (rr_pend) check("rr_order", 64'(acc_owner), 64'(rr_next));
                if ((acc_owner ? eq1.size() : eq0.size()) == 0) begin
                    bound_fail("unexpected_result");
                end else begin
                    e = acc_owner ? eq1.pop_front() : eq0.pop_front();
                    check("acc_out32", 64'(acc_out32), e.r32);
                    check("acc_ovf32", 64'(acc_ovf),   64'(e.o32));
                    check("acc_out10", 64'(acc_out10), e.r10);
                    check("acc_ovf10", 64'(acc_ovf10), 64'(e.o10));
                end
                owner_log.push_back(acc_owner);
                rr_pend = acc_owner ? v0 : v1;
                rr_next = ~acc_owner;
            end
        end
        prev_valid = (rstn === 1'b1) && acc_valid;
    end

    initial begin
        int n, t, base;
        rstn = 1'b0;
        do_reset();

        // Unsigned three-beat burst from requester 0.
        add_beat(8'hFF, 0, 0); add_beat(8'h01, 0, 0); add_beat(8'h10, 0, 1);
        push_burst(0);
        drain("drain_unsigned");

        // Signed two-beat burst from requester 1.
        add_beat(8'h80, 1, 0); add_beat(8'hFF, 1, 1);
        push_burst(1);
        drain("drain_signed");

        // Simultaneous single-beat requests straight out of reset.
        rstn = 1'b0;
        add_beat(8'h05, 0, 1); push_burst(0);
        add_beat(8'h07, 0, 1); push_burst(1);
        n = owner_log.size();
        do_reset();
        drain("drain_both");
        if (owner_log.size() >= n + 2) begin
            check("first_owner",  64'(owner_log[n]),     64'd0);
            check("second_owner", 64'(owner_log[n + 1]), 64'd1);
        end else begin
            bound_fail("owner_log");
        end

        // Five positive maxima: wraps or saturates in the narrow instance.
        repeat (4) add_beat(8'h7F, 1, 0);
        add_beat(8'h7F, 1, 1);
        push_burst(0);
        drain("drain_overflow");

        // Reset after two accepted beats; the held third beat becomes a fresh burst.
        base = cnt0;
        add_beat(8'h11, 0, 0); add_beat(8'h22, 0, 0); add_beat(8'h03, 0, 1);
        push_beats(0, bb);
        bb.delete();
        add_beat(8'h03, 0, 1);
        push_exp(0, bb);
        bb.delete();
        t = 0;
        while (cnt0 < base + 2 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) bound_fail("mid_burst_wait");
        rstn = 1'b0;
        do_reset();
        drain("drain_mid_reset");

        // Randomized contention with stalls.
        stall_en = 1'b1;
        for (int k = 0; k < 25; k++) begin
            for (int id = 0; id < 2; id++) begin
                int len;
                len = $urandom_range(1, 4);
                for (int j = 0; j < len; j++) begin
                    add_beat(8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), j == len - 1);
                end
                push_burst(id);
            end
        end
        drain("drain_random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
